// File: rtl/fp_int_convert_pipe.sv
`timescale 1ns/1ps
// Purpose: pipelined IEEE-754 single/double to int32/uint32/int64/uint64 converter with NV/NX flags and tag passthrough.
// Latency: 3 cycles from accept to out_valid (unpack, align, round/saturate), throughput 1 per cycle.
// Backpressure: all stages stall together while out_valid & !in_out_ready; out_ready_in = !out_valid | in_out_ready.
// Optional rounding modes: define FP_CVT_RM_EN to honour in_rm; otherwise every conversion truncates (RTZ).

module fp_int_convert_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  out_ready_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_fmt,
    input  logic [1:0]            in_output_fmt,
    input  logic [2:0]            in_rm,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  in_out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_flg_NV,
    output logic                  out_flg_NX
);

`ifdef FP_CVT_RM_EN
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
`endif

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                   r1_vld;
    logic                   r1_sign;
    logic signed [12:0]     r1_exp;
    logic [52:0]            r1_sig;
    logic                   r1_zero;
    logic                   r1_sub;
    logic                   r1_inf;
    logic                   r1_nan;
    logic [1:0]             r1_ofmt;
    logic [TAG_WIDTH-1:0]   r1_tag;

    logic                   r2_vld;
    logic                   r2_sign;
    logic [63:0]            r2_int;
    logic                   r2_g;
    logic                   r2_s;
    logic                   r2_ovf;
    logic                   r2_inf;
    logic                   r2_nan;
    logic [1:0]             r2_ofmt;
    logic [TAG_WIDTH-1:0]   r2_tag;

`ifdef FP_CVT_RM_EN
    logic [2:0]             r1_rm;
    logic [2:0]             r2_rm;
`endif

    logic                   r_out_vld;
    logic [DATA_WIDTH-1:0]  r_out_dat;
    logic [TAG_WIDTH-1:0]   r_out_tag;
    logic                   r_out_nv;
    logic                   r_out_nx;

    // Whole pipeline moves as one unit: it advances unless the result is held.
    logic w_adv;
    assign w_adv        = !r_out_vld || in_out_ready;
    assign out_ready_in = w_adv;

    // ------------------------------------------------------------------
    // S1: unpack, widen single to double layout, remove bias, classify
    // ------------------------------------------------------------------
    logic               w_sign;
    logic               w_exp_zero;
    logic               w_exp_ones;
    logic               w_man_zero;
    logic [51:0]        w_man;
    logic signed [12:0] w_exp_unb;

    // Field extraction for the selected source format.
    always_comb begin
        if (in_fmt) begin
            w_sign     = in_data[63];
            w_exp_zero = (in_data[62:52] == 11'h000);
            w_exp_ones = (in_data[62:52] == 11'h7FF);
            w_man      = in_data[51:0];
            w_exp_unb  = $signed({2'b00, in_data[62:52]}) - 13'sd1023;
        end else begin
            w_sign     = in_data[31];
            w_exp_zero = (in_data[30:23] == 8'h00);
            w_exp_ones = (in_data[30:23] == 8'hFF);
            w_man      = {in_data[22:0], 29'd0};
            w_exp_unb  = $signed({5'b00000, in_data[30:23]}) - 13'sd127;
        end
        w_man_zero = (w_man == 52'd0);
    end

    // S1 register: operand class, unbiased exponent and significand with hidden one.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_exp  <= '0;
            r1_sig  <= '0;
            r1_zero <= 1'b0;
            r1_sub  <= 1'b0;
            r1_inf  <= 1'b0;
            r1_nan  <= 1'b0;
            r1_ofmt <= '0;
            r1_tag  <= '0;
`ifdef FP_CVT_RM_EN
            r1_rm   <= '0;
`endif
        end else if (w_adv) begin
            r1_vld  <= in_valid;
            r1_sign <= w_sign;
            r1_exp  <= w_exp_unb;
            r1_sig  <= {1'b1, w_man};
            r1_zero <= w_exp_zero & w_man_zero;
            r1_sub  <= w_exp_zero & !w_man_zero;
            r1_inf  <= w_exp_ones & w_man_zero;
            r1_nan  <= w_exp_ones & !w_man_zero;
            r1_ofmt <= in_output_fmt;
            r1_tag  <= in_tag;
`ifdef FP_CVT_RM_EN
            r1_rm   <= in_rm;
`endif
        end
    end

    // ------------------------------------------------------------------
    // S2: align into 64.64 fixed point; integer part, guard, sticky
    // ------------------------------------------------------------------
    // value = sig * 2^(exp-52); placing it with 64 fraction bits needs a
    // left shift of exp+12, which spans 11..75 for the in-range exponents.
    logic [6:0]   w_shamt;
    logic [127:0] w_fx;
    logic [63:0]  w_int;
    logic         w_g;
    logic         w_s;
    logic         w_ovf;

    assign w_shamt = r1_exp[6:0] + 7'd12;
    assign w_fx    = {75'd0, r1_sig} << w_shamt;

    // Integer/guard/sticky selection per operand class and exponent range.
    always_comb begin
        w_int = '0;
        w_g   = 1'b0;
        w_s   = 1'b0;
        w_ovf = 1'b0;
        if (r1_sub) begin
            // Subnormals are far below 0.5: nothing but sticky survives.
            w_s = 1'b1;
        end else if (!(r1_zero || r1_inf || r1_nan)) begin
            if (r1_exp > 13'sd63) begin
                w_ovf = 1'b1;
            end else if (r1_exp < -13'sd1) begin
                w_s = 1'b1;
            end else begin
                w_int = w_fx[127:64];
                w_g   = w_fx[63];
                w_s   = |w_fx[62:0];
            end
        end
    end

    // S2 register: aligned magnitude and rounding information.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r2_vld  <= 1'b0;
            r2_sign <= 1'b0;
            r2_int  <= '0;
            r2_g    <= 1'b0;
            r2_s    <= 1'b0;
            r2_ovf  <= 1'b0;
            r2_inf  <= 1'b0;
            r2_nan  <= 1'b0;
            r2_ofmt <= '0;
            r2_tag  <= '0;
`ifdef FP_CVT_RM_EN
            r2_rm   <= '0;
`endif
        end else if (w_adv) begin
            r2_vld  <= r1_vld;
            r2_sign <= r1_sign;
            r2_int  <= w_int;
            r2_g    <= w_g;
            r2_s    <= w_s;
            r2_ovf  <= w_ovf;
            r2_inf  <= r1_inf;
            r2_nan  <= r1_nan;
            r2_ofmt <= r1_ofmt;
            r2_tag  <= r1_tag;
`ifdef FP_CVT_RM_EN
            r2_rm   <= r1_rm;
`endif
        end
    end

    // ------------------------------------------------------------------
    // S3: round magnitude, range check, negate, saturate, flags
    // ------------------------------------------------------------------
    logic        w_rup;
    logic [64:0] w_mag;
    logic        w_pos_ovf;
    logic        w_neg_ovf;
    logic [63:0] w_max;
    logic [63:0] w_min;
    logic [63:0] w_val;
    logic [63:0] w_res;
    logic        w_nv;
    logic        w_nx;

`ifdef FP_CVT_RM_EN
    // Round-up decision on the magnitude; RTZ and reserved encodings truncate.
    always_comb begin
        case (r2_rm)
            RM_RNE:  w_rup = r2_g & (r2_s | r2_int[0]);
            RM_RDN:  w_rup = r2_sign & (r2_g | r2_s);
            RM_RUP:  w_rup = !r2_sign & (r2_g | r2_s);
            RM_RMM:  w_rup = r2_g;
            default: w_rup = 1'b0;
        endcase
    end
`else
    // Truncation only; the rounding-mode port is kept for pin compatibility.
    logic w_unused_rm;
    assign w_unused_rm = ^in_rm;
    assign w_rup       = 1'b0;
`endif

    // Extra bit keeps the carry when a 64-bit magnitude rounds up.
    assign w_mag = {1'b0, r2_int} + {64'd0, w_rup};

    // Format limits and range check, applied after rounding.
    always_comb begin
        case (r2_ofmt)
            2'b00: begin
                w_pos_ovf = (w_mag > 65'h0_7FFF_FFFF);
                w_neg_ovf = (w_mag > 65'h0_8000_0000);
                w_max     = 64'h0000_0000_7FFF_FFFF;
                w_min     = 64'hFFFF_FFFF_8000_0000;
            end
            2'b01: begin
                w_pos_ovf = (w_mag > 65'h0_FFFF_FFFF);
                w_neg_ovf = (w_mag != 65'd0);
                w_max     = 64'hFFFF_FFFF_FFFF_FFFF;
                w_min     = 64'd0;
            end
            2'b10: begin
                w_pos_ovf = (w_mag > 65'h0_7FFF_FFFF_FFFF_FFFF);
                w_neg_ovf = (w_mag > 65'h0_8000_0000_0000_0000);
                w_max     = 64'h7FFF_FFFF_FFFF_FFFF;
                w_min     = 64'h8000_0000_0000_0000;
            end
            default: begin
                w_pos_ovf = w_mag[64];
                w_neg_ovf = (w_mag != 65'd0);
                w_max     = 64'hFFFF_FFFF_FFFF_FFFF;
                w_min     = 64'd0;
            end
        endcase
    end

    // Final result: NaN/inf/out-of-range saturate with NV, else signed value with NX.
    always_comb begin
        w_val = r2_sign ? (~w_mag[63:0] + 64'd1) : w_mag[63:0];
        w_res = '0;
        w_nv  = 1'b0;
        w_nx  = 1'b0;
        if (r2_nan) begin
            w_res = w_max;
            w_nv  = 1'b1;
        end else if (r2_inf || r2_ovf || (r2_sign ? w_neg_ovf : w_pos_ovf)) begin
            w_res = r2_sign ? w_min : w_max;
            w_nv  = 1'b1;
        end else begin
            w_nx  = r2_g | r2_s;
            // 32-bit results (signed or not) are sign-extended from bit 31.
            w_res = r2_ofmt[1] ? w_val : {{32{w_val[31]}}, w_val[31:0]};
        end
    end

    // Output register: held while the consumer stalls.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_tag <= '0;
            r_out_nv  <= 1'b0;
            r_out_nx  <= 1'b0;
        end else if (w_adv) begin
            r_out_vld <= r2_vld;
            r_out_dat <= w_res;
            r_out_tag <= r2_tag;
            r_out_nv  <= w_nv;
            r_out_nx  <= w_nx;
        end
    end

    assign out_valid  = r_out_vld;
    assign out_data   = r_out_dat;
    assign out_tag    = r_out_tag;
    assign out_flg_NV = r_out_nv;
    assign out_flg_NX = r_out_nx;

endmodule

// File: tb/tb_fp_int_convert_pipe.sv
`timescale 1ns/1ps
// Bench for fp_int_convert_pipe: vector table streamed through a scoreboard,
// plus latency, back-pressure and mid-flight reset sequences.
// Expected values carry both the rounded and the truncating answer; the build macro picks one.

module tb_fp_int_convert_pipe;

    localparam logic       F_S = 1'b0;
    localparam logic       F_D = 1'b1;
    localparam logic [1:0] I32 = 2'b00;
    localparam logic [1:0] U32 = 2'b01;
    localparam logic [1:0] I64 = 2'b10;
    localparam logic [1:0] U64 = 2'b11;
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam int         NVEC = 31;

    typedef struct {
        logic [63:0] dat;
        logic        fmt;
        logic [1:0]  ofmt;
        logic [2:0]  rm;
        logic [63:0] e_rm;   // result with rounding modes honoured
        logic [1:0]  f_rm;   // {NV, NX}
        logic [63:0] e_tz;   // result with truncation only
        logic [1:0]  f_tz;
    } vec_t;

    typedef struct {
        logic [63:0] dat;
        logic        nv;
        logic        nx;
        logic [4:0]  tag;
    } exp_t;

    logic        in_clk;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready_in;
    logic [63:0] in_data;
    logic        in_fmt;
    logic [1:0]  in_output_fmt;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        in_out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;
    logic        out_flg_NV;
    logic        out_flg_NX;

    vec_t vt [NVEC];
    exp_t sb_q [$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rx  = 0;
    logic seen_stall = 1'b0;

    fp_int_convert_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_valid      (in_valid),
        .out_ready_in  (out_ready_in),
        .in_data       (in_data),
        .in_fmt        (in_fmt),
        .in_output_fmt (in_output_fmt),
        .in_rm         (in_rm),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .in_out_ready  (in_out_ready),
        .out_data      (out_data),
        .out_tag       (out_tag),
        .out_flg_NV    (out_flg_NV),
        .out_flg_NX    (out_flg_NX)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, required 0x%016h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", nm, act, exp);
        end
    endtask

    function automatic exp_t exp_of(input vec_t v, input logic [4:0] tag);
        exp_t e;
`ifdef FP_CVT_RM_EN
        e.dat = v.e_rm;
        e.nv  = v.f_rm[1];
        e.nx  = v.f_rm[0];
`else
        e.dat = v.e_tz;
        e.nv  = v.f_tz[1];
        e.nx  = v.f_tz[0];
`endif
        e.tag = tag;
        return e;
    endfunction

    // Scoreboard: compare each presented result with the oldest expectation.
    // While stalled the same expectation is re-checked every cycle, so any
    // drift of the held outputs shows up.
    always @(negedge in_clk) begin
        if (!in_rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: out_valid=1 tag=%0d data=0x%016h, required no result", out_tag, out_data);
            end else begin
                mon_e = sb_q[0];
                chk64("data", out_data, mon_e.dat);
                chk64("tag", {59'd0, out_tag}, {59'd0, mon_e.tag});
                chk1("flag_NV", out_flg_NV, mon_e.nv);
                chk1("flag_NX", out_flg_NX, mon_e.nx);
                if (in_out_ready) begin
                    void'(sb_q.pop_front());
                    n_rx++;
                end else begin
                    chk1("stall_ready_in", out_ready_in, 1'b0);
                end
            end
        end
    end

    // Drive one operand (entered and left at posedge+1), waiting for acceptance.
    task automatic send(input vec_t v, input logic [4:0] tag);
        int w;
        w             = 0;
        in_valid      = 1'b1;
        in_data       = v.dat;
        in_fmt        = v.fmt;
        in_output_fmt = v.ofmt;
        in_rm         = v.rm;
        in_tag        = tag;
        #1;
        while (!out_ready_in && w < 50) begin
            seen_stall = 1'b1;
            @(posedge in_clk);
            #2;
            w++;
        end
        chk1("accept", out_ready_in, 1'b1);
        if (out_ready_in) sb_q.push_back(exp_of(v, tag));
        @(posedge in_clk);
        #1;
    endtask

    // Single operand into an empty pipe; out_valid must rise in the third cycle.
    task automatic lat_one(input vec_t v, input logic [4:0] tag);
        send(v, tag);
        in_valid = 1'b0;
        @(negedge in_clk);
        chk1("latency_c1", out_valid, 1'b0);
        @(posedge in_clk);
        @(negedge in_clk);
        chk1("latency_c2", out_valid, 1'b0);
        @(posedge in_clk);
        @(negedge in_clk);
        chk1("latency_c3", out_valid, 1'b1);
        @(posedge in_clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge in_clk);
            #1;
            w++;
        end
        chk64("drain_left", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk1({nm, "_valid"}, out_valid, 1'b0);
        chk64({nm, "_data"}, out_data, 64'd0);
        chk64({nm, "_tag"}, {59'd0, out_tag}, 64'd0);
        chk1({nm, "_NV"}, out_flg_NV, 1'b0);
        chk1({nm, "_NX"}, out_flg_NX, 1'b0);
    endtask

    initial begin
        //           operand                 fmt  ofmt rm   rounded result           {NV,NX} truncated result        {NV,NX}
        vt[0]  = '{64'h0000_0000_4020_0000, F_S, I32, RNE, 64'h0000_0000_0000_0002, 2'b01, 64'h0000_0000_0000_0002, 2'b01};
        vt[1]  = '{64'h0000_0000_4020_0000, F_S, I32, RUP, 64'h0000_0000_0000_0003, 2'b01, 64'h0000_0000_0000_0002, 2'b01};
        vt[2]  = '{64'h0000_0000_4020_0000, F_S, I32, RMM, 64'h0000_0000_0000_0003, 2'b01, 64'h0000_0000_0000_0002, 2'b01};
        vt[3]  = '{64'h0000_0000_4020_0000, F_S, I32, RDN, 64'h0000_0000_0000_0002, 2'b01, 64'h0000_0000_0000_0002, 2'b01};
        vt[4]  = '{64'h0000_0000_4F00_0000, F_S, I32, RTZ, 64'h0000_0000_7FFF_FFFF, 2'b10, 64'h0000_0000_7FFF_FFFF, 2'b10};
        vt[5]  = '{64'h0000_0000_4F00_0000, F_S, U32, RTZ, 64'hFFFF_FFFF_8000_0000, 2'b00, 64'hFFFF_FFFF_8000_0000, 2'b00};
        vt[6]  = '{64'hBFF8_0000_0000_0000, F_D, U64, RTZ, 64'h0000_0000_0000_0000, 2'b10, 64'h0000_0000_0000_0000, 2'b10};
        vt[7]  = '{64'hBFD9_9999_9999_999A, F_D, U64, RTZ, 64'h0000_0000_0000_0000, 2'b01, 64'h0000_0000_0000_0000, 2'b01};
        vt[8]  = '{64'h0000_0000_7FC0_0000, F_S, I64, RTZ, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10};
        vt[9]  = '{64'hFFF0_0000_0000_0000, F_D, I64, RTZ, 64'h8000_0000_0000_0000, 2'b10, 64'h8000_0000_0000_0000, 2'b10};
        vt[10] = '{64'h0000_0000_0000_0000, F_S, I32, RUP, 64'h0000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000, 2'b00};
        vt[11] = '{64'h0000_0000_8000_0000, F_S, I64, RDN, 64'h0000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000, 2'b00};
        vt[12] = '{64'h0000_0000_0000_0001, F_S, I32, RUP, 64'h0000_0000_0000_0001, 2'b01, 64'h0000_0000_0000_0000, 2'b01};
        vt[13] = '{64'h0000_0000_8000_0001, F_S, I32, RDN, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0000_0000_0000_0000, 2'b01};
        vt[14] = '{64'hC004_0000_0000_0000, F_D, I64, RNE, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01};
        vt[15] = '{64'hC00C_0000_0000_0000, F_D, I32, RNE, 64'hFFFF_FFFF_FFFF_FFFC, 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 2'b01};
        vt[16] = '{64'h43E0_0000_0000_0000, F_D, I64, RTZ, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10};
        vt[17] = '{64'hC3E0_0000_0000_0000, F_D, I64, RTZ, 64'h8000_0000_0000_0000, 2'b00, 64'h8000_0000_0000_0000, 2'b00};
        vt[18] = '{64'h43E0_0000_0000_0000, F_D, U64, RTZ, 64'h8000_0000_0000_0000, 2'b00, 64'h8000_0000_0000_0000, 2'b00};
        vt[19] = '{64'h0000_0000_7F80_0000, F_S, U32, RTZ, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
        vt[20] = '{64'h0000_0000_FF80_0000, F_S, U32, RTZ, 64'h0000_0000_0000_0000, 2'b10, 64'h0000_0000_0000_0000, 2'b10};
        vt[21] = '{64'h3FE0_0000_0000_0000, F_D, I64, RMM, 64'h0000_0000_0000_0001, 2'b01, 64'h0000_0000_0000_0000, 2'b01};
        vt[22] = '{64'h0000_0000_3F80_0000, F_S, I32, RNE, 64'h0000_0000_0000_0001, 2'b00, 64'h0000_0000_0000_0001, 2'b00};
        vt[23] = '{64'h0000_0000_BF80_0000, F_S, U32, RTZ, 64'h0000_0000_0000_0000, 2'b10, 64'h0000_0000_0000_0000, 2'b10};
        vt[24] = '{64'h0000_0000_CF00_0000, F_S, I32, RTZ, 64'hFFFF_FFFF_8000_0000, 2'b00, 64'hFFFF_FFFF_8000_0000, 2'b00};
        vt[25] = '{64'h0000_0000_4F80_0000, F_S, U32, RTZ, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
        vt[26] = '{64'h43F0_0000_0000_0000, F_D, U64, RTZ, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
        vt[27] = '{64'h41DF_FFFF_FFE0_0000, F_D, I32, RUP, 64'h0000_0000_7FFF_FFFF, 2'b10, 64'h0000_0000_7FFF_FFFF, 2'b01};
        vt[28] = '{64'h3FF8_0000_0000_0000, F_D, I32, RNE, 64'h0000_0000_0000_0002, 2'b01, 64'h0000_0000_0000_0001, 2'b01};
        vt[29] = '{64'h0000_0000_4EFF_FFFF, F_S, I32, RTZ, 64'h0000_0000_7FFF_FF80, 2'b00, 64'h0000_0000_7FFF_FF80, 2'b00};
        vt[30] = '{64'hDEAD_BEEF_3F80_0000, F_S, I32, RTZ, 64'h0000_0000_0000_0001, 2'b00, 64'h0000_0000_0000_0001, 2'b00};

        in_rst        = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_fmt        = 1'b0;
        in_output_fmt = '0;
        in_rm         = '0;
        in_tag        = '0;
        in_out_ready  = 1'b1;

        // Reset state.
        repeat (3) @(posedge in_clk);
        #1;
        chk_zero_outputs("reset");
        chk1("reset_ready_in", out_ready_in, 1'b1);
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;

        // 2.5 under RNE/RUP/RMM, each in an empty pipe to pin down latency.
        for (int i = 0; i < 3; i++) lat_one(vt[i], 5'(i));
        drain();

        // Whole table back to back, consumer always ready.
        for (int i = 0; i < NVEC; i++) send(vt[i], 5'(i));
        in_valid = 1'b0;
        drain();

        // Back-pressure: six operands with a four-cycle consumer stall mid-stream.
        n_rx       = 0;
        seen_stall = 1'b0;
        fork
            begin
                repeat (4) @(posedge in_clk);
                #1;
                in_out_ready = 1'b0;
                repeat (4) @(posedge in_clk);
                #1;
                in_out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 6; k++) send(vt[k + 4], 5'(k));
                in_valid = 1'b0;
            end
        join
        drain();
        chk64("bp_result_count", 64'(n_rx), 64'd6);
        chk1("bp_ready_in_dropped", seen_stall, 1'b1);

        // Reset with two operands in flight.
        send(vt[4], 5'd10);
        send(vt[5], 5'd11);
        in_valid = 1'b0;
        in_rst   = 1'b1;
        sb_q.delete();
        @(posedge in_clk);
        #1;
        chk_zero_outputs("midrst");
        in_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge in_clk);
            #1;
            chk1("midrst_no_stale", out_valid, 1'b0);
        end
        lat_one(vt[22], 5'd20);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
